// File: rtl/uart_pkg.sv
// Shared register offsets, STATUS bit positions and FSM state encoding
// for the UART bus responder.
package uart_pkg;

  localparam logic [31:0] OFF_TXD    = 32'h0;
  localparam logic [31:0] OFF_RXD    = 32'h4;
  localparam logic [31:0] OFF_STATUS = 32'h8;

  localparam int unsigned ST_TX_FULL      = 0;
  localparam int unsigned ST_TX_BUSY      = 1;
  localparam int unsigned ST_RX_VALID     = 2;
  localparam int unsigned ST_RX_OVERRUN   = 3;
  localparam int unsigned ST_RX_FRAME_ERR = 4;
  localparam int unsigned ST_TX_DROP      = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } uart_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// 4-entry, 8-bit transmit FIFO. Pushes while full and pops while empty
// are ignored.
module uart_tx_fifo (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty,
  output logic [2:0] count
);

  logic [7:0] mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic       do_push;
  logic       do_pop;

  assign full    = (count == 3'd4);
  assign empty   = (count == 3'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 2'd1;
      if (do_pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_bus_responder.sv
// Memory-mapped UART: TXD/RXD/STATUS registers, 4-deep TX FIFO,
// 8N1 transmitter and receiver sharing one baud divisor.
module uart_bus_responder
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 70000000,
  parameter int unsigned BAUD      = 9600,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Read,
  input  logic        Write,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  output logic [31:0] Read_data,
  input  logic        rx,
  output logic        tx
);

  localparam int unsigned DIV = CLK_FREQ / BAUD;
  localparam int unsigned CW  = $clog2(DIV);

  logic txd_wr, rxd_rd, stat_wr;
  logic hit_txd, hit_rxd, hit_stat;

  assign hit_txd  = (Address == BASE_ADDR + OFF_TXD);
  assign hit_rxd  = (Address == BASE_ADDR + OFF_RXD);
  assign hit_stat = (Address == BASE_ADDR + OFF_STATUS);
  assign txd_wr   = Write && hit_txd;
  assign rxd_rd   = Read && hit_rxd;
  assign stat_wr  = Write && hit_stat;

  logic       unused_bits;
  assign unused_bits = ^Write_data[31:8];

  // ---------------- transmit path ----------------
  logic [7:0] fifo_dout;
  logic       fifo_full, fifo_empty, tx_pop;
  logic [2:0] fifo_count;

  uart_tx_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (txd_wr),
    .pop   (tx_pop),
    .din   (Write_data[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  uart_state_t   tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;

  // The head entry stays in the FIFO while it is being shifted and is
  // retired one cycle before the stop bit ends; the single IDLE cycle that
  // follows completes the stop bit, so queued frames run with no gap.
  assign tx_pop = (tx_state == S_STOP) && (tx_cnt == CW'(DIV - 2));

  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx       <= 1'b1;
    end else begin
      case (tx_state)
        S_IDLE: begin
          tx <= 1'b1;
          if (!fifo_empty) begin
            tx_shift <= fifo_dout;
            tx_cnt   <= '0;
            tx       <= 1'b0;
            tx_state <= S_START;
          end
        end
        S_START: begin
          if (tx_cnt == CW'(DIV - 1)) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx       <= tx_shift[0];
            tx_state <= S_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (tx_cnt == CW'(DIV - 1)) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              tx       <= 1'b1;
              tx_state <= S_STOP;
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              tx_shift <= tx_shift >> 1;
              tx       <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (tx_pop) begin
            tx_cnt   <= '0;
            tx_state <= S_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= S_IDLE;
      endcase
    end
  end

  // ---------------- receive path ----------------
  logic          rx_meta, rx_sync, rx_prev;
  uart_state_t   rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_hold;
  logic          rx_tick, good_frame, bad_frame;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_tick    = (rx_cnt == CW'(DIV - 1));
  assign good_frame = (rx_state == S_STOP) && !rx_hold && rx_tick && rx_sync;
  assign bad_frame  = (rx_state == S_STOP) && !rx_hold && rx_tick && !rx_sync;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_hold  <= 1'b0;
    end else begin
      case (rx_state)
        S_IDLE: begin
          if (rx_prev && !rx_sync) begin
            rx_cnt   <= '0;
            rx_state <= S_START;
          end
        end
        S_START: begin
          if (rx_cnt == CW'(DIV / 2 - 1)) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_sync ? S_IDLE : S_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (rx_tick) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= S_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (rx_hold) begin
            // bad stop bit: stay here until the line is released
            if (rx_sync) begin
              rx_hold  <= 1'b0;
              rx_state <= S_IDLE;
            end
          end else if (rx_tick) begin
            rx_cnt <= '0;
            if (rx_sync) rx_state <= S_IDLE;
            else         rx_hold  <= 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

  // ---------------- status registers ----------------
  logic [7:0] rx_byte;
  logic       rx_valid, rx_overrun, rx_frame_err, tx_drop;
  logic       tx_busy, tx_full;

  assign tx_busy = !fifo_empty || (tx_state != S_IDLE);
  assign tx_full = (fifo_count == 3'd4);

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_byte      <= '0;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
      tx_drop      <= 1'b0;
    end else begin
      if (good_frame && (!rx_valid || rxd_rd)) begin
        rx_byte  <= rx_shift;
        rx_valid <= 1'b1;
      end else if (rxd_rd) begin
        rx_valid <= 1'b0;
      end
      rx_overrun   <= (good_frame && rx_valid && !rxd_rd) ||
                      (rx_overrun && !(stat_wr && Write_data[ST_RX_OVERRUN]));
      rx_frame_err <= bad_frame ||
                      (rx_frame_err && !(stat_wr && Write_data[ST_RX_FRAME_ERR]));
      tx_drop      <= (txd_wr && fifo_full) ||
                      (tx_drop && !(stat_wr && Write_data[ST_TX_DROP]));
    end
  end

  logic [31:0] status_word;
  assign status_word = {26'b0, tx_drop, rx_frame_err, rx_overrun,
                        rx_valid, tx_busy, tx_full};

  always_comb begin
    Read_data = '0;
    if (Read) begin
      if (hit_rxd)       Read_data = {24'h0, rx_byte};
      else if (hit_stat) Read_data = status_word;
    end
  end

endmodule
